data_unloader: RTL and testbench

DATA_UNLOADER -- requirements
Module: data_unloader

---
 rtl/data_unloader.sv | 208 ++++++++++++++++++++
 tb/tb_data_unloader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_unloader.sv
// Streams 512-bit lines out of a core's data memory and writes them to Avalon memory,
// one single-beat burst per line, assembled from sixteen 32-bit dmem reads.
module data_unloader #(
    parameter int CORES      = 4,
    parameter int DMEM_DEPTH = 14
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  kick,
    output logic                                  busy,
    output logic                                  done,
    input  logic [63:0]                           memory_base_addr,
    input  logic [$clog2(CORES)-1:0]              target_core,
    input  logic [DMEM_DEPTH-4:0]                 num_lines,
    output logic [$clog2(CORES)+DMEM_DEPTH+1:0]   data_addr,
    output logic                                  data_re,
    input  logic [31:0]                           data_din,
    input  logic                                  m0_waitrequest,
    input  logic [511:0]                          m0_readdata,
    input  logic                                  m0_readdatavalid,
    output logic [2:0]                            m0_burstcount,
    output logic [511:0]                          m0_writedata,
    output logic [63:0]                           m0_address,
    output logic                                  m0_write,
    output logic                                  m0_read,
    output logic [63:0]                           m0_byteenable,
    output logic                                  m0_debugaccess
);
    localparam int CW        = $clog2(CORES);
    localparam int LW        = DMEM_DEPTH - 4;
    localparam int NW        = DMEM_DEPTH - 3;
    localparam int AW        = CW + DMEM_DEPTH + 2;
    localparam int MAX_LINES = 1 << LW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      word_r, word_s;
    logic [LW-1:0]   line_r, line_s;
    logic [NW-1:0]   lines_r, lines_s;
    logic [63:0]     base_r, base_s;
    logic [CW-1:0]   core_r, core_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            data_re_r, data_re_s;
    logic            din_valid_r;
    logic [AW-1:0]   data_addr_r, data_addr_s;
    logic            m0_write_r, m0_write_s;
    logic [63:0]     m0_address_r, m0_address_s;
    logic [63:0]     byteen_r, byteen_s;
    logic [511:0]    line_buf_r, line_buf_s;
    logic            last_line_s;
    logic            unused_s;

    assign unused_s    = ^{m0_readdata, m0_readdatavalid};
    assign last_line_s = ({1'b0, line_r} == (lines_r - NW'(1)));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of every registered output and counter
    always_comb begin
        state_s      = state_r;
        word_s       = word_r;
        line_s       = line_r;
        lines_s      = lines_r;
        base_s       = base_r;
        core_s       = core_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        data_re_s    = 1'b0;
        data_addr_s  = data_addr_r;
        m0_write_s   = m0_write_r;
        m0_address_s = m0_address_r;
        byteen_s     = byteen_r;
        // Each read word lands at the LSB; the first word ends up in the top lane.
        if (din_valid_r) begin
            line_buf_s = {line_buf_r[479:0], data_din};
        end else begin
            line_buf_s = line_buf_r;
        end
        case (state_r)
            IDLE: begin
                if (kick) begin
                    base_s = memory_base_addr;
                    core_s = target_core;
                    line_s = {LW{1'b0}};
                    if (num_lines > NW'(MAX_LINES)) begin
                        lines_s = NW'(MAX_LINES);
                    end else begin
                        lines_s = num_lines;
                    end
                    if (num_lines == {NW{1'b0}}) begin
                        // Nothing to move: WRITE with done set acts as the one-cycle done state.
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        word_s  = 4'd0;
                        state_s = WRITE;
                    end else begin
                        busy_s      = 1'b1;
                        data_re_s   = 1'b1;
                        data_addr_s = {target_core, {LW{1'b0}}, 4'd0, 2'b00};
                        word_s      = 4'd1;
                        state_s     = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                data_re_s   = 1'b1;
                data_addr_s = {core_r, line_r, word_r, 2'b00};
                word_s      = word_r + 4'd1;
                if (word_r == 4'd15) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FETCH;
                end
            end
            DRAIN: begin
                byteen_s = {64{1'b1}};
                state_s  = WRITE;
            end
            WRITE: begin
                if (done_r) begin
                    state_s = IDLE;
                end else if (!m0_write_r) begin
                    // Last word is shifted in on this same edge.
                    m0_write_s   = 1'b1;
                    m0_address_s = base_r + {{(58 - LW){1'b0}}, line_r, 6'b000000};
                end else if (!m0_waitrequest) begin
                    m0_write_s = 1'b0;
                    byteen_s   = {64{1'b0}};
                    if (last_line_s) begin
                        done_s = 1'b1;
                        busy_s = 1'b0;
                    end else begin
                        line_s  = line_r + LW'(1);
                        state_s = FETCH;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r       <= 4'd0;
            line_r       <= {LW{1'b0}};
            lines_r      <= {NW{1'b0}};
            base_r       <= 64'd0;
            core_r       <= {CW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            data_re_r    <= 1'b0;
            din_valid_r  <= 1'b0;
            data_addr_r  <= {AW{1'b0}};
            m0_write_r   <= 1'b0;
            m0_address_r <= 64'd0;
            byteen_r     <= 64'd0;
            line_buf_r   <= 512'd0;
        end else begin
            word_r       <= word_s;
            line_r       <= line_s;
            lines_r      <= lines_s;
            base_r       <= base_s;
            core_r       <= core_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            data_re_r    <= data_re_s;
            din_valid_r  <= data_re_r;
            data_addr_r  <= data_addr_s;
            m0_write_r   <= m0_write_s;
            m0_address_r <= m0_address_s;
            byteen_r     <= byteen_s;
            line_buf_r   <= line_buf_s;
        end
    end

    assign busy           = busy_r | kick;
    assign done           = done_r;
    assign data_re        = data_re_r;
    assign data_addr      = data_addr_r;
    assign m0_write       = m0_write_r;
    assign m0_address     = m0_address_r;
    assign m0_writedata   = line_buf_r;
    assign m0_byteenable  = byteen_r;
    assign m0_burstcount  = 3'd1;
    assign m0_read        = 1'b0;
    assign m0_debugaccess = 1'b0;
endmodule

// File: tb/tb_data_unloader.sv
// Directed bench for data_unloader: dmem responder, Avalon write logger, and a linear
// sequence of transfers checked with immediate assertions.
module tb_data_unloader;
    logic         clk = 1'b0;
    logic         reset, kick, busy, done, data_re, m0_waitrequest, m0_readdatavalid;
    logic [63:0]  memory_base_addr, m0_address, m0_byteenable;
    logic [1:0]   target_core;
    logic [10:0]  num_lines;
    logic [17:0]  data_addr;
    logic [31:0]  data_din = 32'd0;
    logic [511:0] m0_readdata, m0_writedata;
    logic [2:0]   m0_burstcount;
    logic         m0_write, m0_read, m0_debugaccess;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    data_unloader dut (
        .clk(clk), .reset(reset), .kick(kick), .busy(busy), .done(done),
        .memory_base_addr(memory_base_addr), .target_core(target_core), .num_lines(num_lines),
        .data_addr(data_addr), .data_re(data_re), .data_din(data_din),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_burstcount(m0_burstcount),
        .m0_writedata(m0_writedata), .m0_address(m0_address), .m0_write(m0_write),
        .m0_read(m0_read), .m0_byteenable(m0_byteenable), .m0_debugaccess(m0_debugaccess)
    );

    // dmem model: word w of any core holds 0x100 + w, returned one cycle after the strobe
    always @(posedge clk) begin
        if (data_re) data_din <= 32'h100 + 32'(data_addr[15:2]);
        else         data_din <= 32'hDEAD_BEEF;
    end

    int cyc = 0, re_cnt = 0, wr_cnt = 0, done_cnt = 0, stab_err = 0;
    int last_re_cyc = 0, last_rise_gap = 0;
    logic [17:0]  re_addr_a [0:65535];
    logic [63:0]  wr_addr_a [0:4095];
    logic [511:0] wr_data_a [0:4095];
    logic         prev_write = 1'b0, prev_stall = 1'b0;
    logic [63:0]  prev_addr = 64'd0;
    logic [511:0] prev_data = 512'd0;

    // Logger sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (data_re) begin
            if (re_cnt < 65536) re_addr_a[re_cnt] <= data_addr;
            re_cnt      <= re_cnt + 1;
            last_re_cyc <= cyc;
        end
        if (m0_write && !prev_write) last_rise_gap <= cyc - last_re_cyc;
        if (m0_write && prev_stall && (m0_address !== prev_addr || m0_writedata !== prev_data))
            stab_err <= stab_err + 1;
        if (m0_write && !m0_waitrequest) begin
            if (wr_cnt < 4096) begin
                wr_addr_a[wr_cnt] <= m0_address;
                wr_data_a[wr_cnt] <= m0_writedata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        prev_write <= m0_write;
        prev_stall <= m0_write && m0_waitrequest;
        prev_addr  <= m0_address;
        prev_data  <= m0_writedata;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] exp_line(input int l);
        logic [511:0] e;
        e = 512'd0;
        for (int j = 0; j < 16; j++) e[511 - 32*j -: 32] = 32'h100 + 32'(16*l + j);
        return e;
    endfunction

    // Steps until done (bounded); stall > 0 holds waitrequest for that many cycles per write
    task automatic wait_done(input int limit, input int stall, output int n);
        int st;
        n  = 0;
        st = 0;
        while (!done && n < limit) begin
            step();
            n++;
            if (stall == 0) begin
                m0_waitrequest = 1'b0;
            end else if (m0_write) begin
                st++;
                m0_waitrequest = (st < stall + 1);
            end else begin
                st = 0;
                m0_waitrequest = 1'b1;
            end
        end
        check("done_seen", 512'(done), 512'(1'b1));
    endtask

    task automatic start(input logic [1:0] core, input logic [10:0] lines, input logic [63:0] base);
        target_core      = core;
        num_lines        = lines;
        memory_base_addr = base;
        kick             = 1'b1;
        step();
        kick             = 1'b0;
    endtask

    initial begin
        int n, b_re, b_wr, b_done, b_stab;
        reset = 1'b1; kick = 1'b0; memory_base_addr = 64'd0; target_core = 2'd0;
        num_lines = 11'd0; m0_waitrequest = 1'b0; m0_readdata = 512'd0; m0_readdatavalid = 1'b0;
        repeat (3) step();
        check("rst_busy", 512'(busy), 512'(1'b0));
        check("rst_done", 512'(done), 512'(1'b0));
        check("rst_data_re", 512'(data_re), 512'(1'b0));
        check("rst_write", 512'(m0_write), 512'(1'b0));
        check("rst_addr", 512'(m0_address), 512'd0);
        check("rst_wdata", m0_writedata, 512'd0);
        check("rst_be", 512'(m0_byteenable), 512'd0);
        check("const_burst", 512'(m0_burstcount), 512'(3'd1));
        check("const_rd_dbg", 512'({m0_read, m0_debugaccess}), 512'(2'b00));
        reset = 1'b0;
        step();

        // Single line from core 2
        b_re = re_cnt; b_wr = wr_cnt; b_done = done_cnt;
        target_core = 2'd2; num_lines = 11'd1; memory_base_addr = 64'h1000; kick = 1'b1;
        #1 check("busy_comb", 512'(busy), 512'(1'b1));
        step();
        kick = 1'b0;
        check("t1_re_latency", 512'(data_re), 512'(1'b1));
        check("t1_first_daddr", 512'(data_addr), 512'(18'h20000));
        wait_done(200, 0, n);
        check("t1_done_latency", 512'(n), 512'(18));
        check("t1_write_gap", 512'(last_rise_gap), 512'(2));
        step();
        check("t1_idle", 512'({busy, done, m0_write}), 512'(3'b000));
        check("t1_re_count", 512'(re_cnt - b_re), 512'(16));
        check("t1_last_daddr", 512'(re_addr_a[b_re + 15]), 512'(18'h2003C));
        check("t1_wr_count", 512'(wr_cnt - b_wr), 512'(1));
        check("t1_wr_addr", 512'(wr_addr_a[b_wr]), 512'(64'h1000));
        check("t1_wr_top", 512'(wr_data_a[b_wr][511:480]), 512'(32'h100));
        check("t1_wr_bot", 512'(wr_data_a[b_wr][31:0]), 512'(32'h10F));
        check("t1_wr_line", wr_data_a[b_wr], exp_line(0));
        check("t1_done_once", 512'(done_cnt - b_done), 512'(1));

        // Three lines with a 5-cycle stall on every write
        b_re = re_cnt; b_wr = wr_cnt; b_done = done_cnt; b_stab = stab_err;
        m0_waitrequest = 1'b1;
        start(2'd1, 11'd3, 64'h2000);
        wait_done(400, 5, n);
        step();
        check("t2_done_latency", 512'(n), 512'(71));
        check("t2_wr_count", 512'(wr_cnt - b_wr), 512'(3));
        check("t2_addr0", 512'(wr_addr_a[b_wr]), 512'(64'h2000));
        check("t2_addr1", 512'(wr_addr_a[b_wr + 1]), 512'(64'h2040));
        check("t2_addr2", 512'(wr_addr_a[b_wr + 2]), 512'(64'h2080));
        check("t2_line2", wr_data_a[b_wr + 2], exp_line(2));
        check("t2_stable", 512'(stab_err - b_stab), 512'(0));
        check("t2_done_once", 512'(done_cnt - b_done), 512'(1));

        // Zero lines
        b_re = re_cnt; b_wr = wr_cnt;
        m0_waitrequest = 1'b0;
        start(2'd0, 11'd0, 64'h9000);
        check("t3_done_pulse", 512'({done, data_re, m0_write}), 512'(3'b100));
        step();
        check("t3_after", 512'({done, busy}), 512'(2'b00));
        repeat (5) step();
        check("t3_no_traffic", 512'({re_cnt - b_re, wr_cnt - b_wr}), 512'(0));

        // Kick held through the transfer and its done cycle
        b_wr = wr_cnt; b_done = done_cnt;
        target_core = 2'd0; num_lines = 11'd1; memory_base_addr = 64'h3000; kick = 1'b1;
        step();
        wait_done(200, 0, n);
        check("t4_done_latency", 512'(n), 512'(18));
        step();
        kick = 1'b0;
        repeat (5) step();
        check("t4_no_restart", 512'({data_re, busy}), 512'(2'b00));
        check("t4_one_write", 512'(wr_cnt - b_wr), 512'(1));
        check("t4_one_done", 512'(done_cnt - b_done), 512'(1));
        b_re = re_cnt; b_wr = wr_cnt;
        start(2'd1, 11'd1, 64'h4000);
        wait_done(200, 0, n);
        step();
        check("t4_second_daddr", 512'(re_addr_a[b_re]), 512'(18'h10000));
        check("t4_second_addr", 512'(wr_addr_a[b_wr]), 512'(64'h4000));

        // Reset while a write is stalled
        m0_waitrequest = 1'b1;
        start(2'd3, 11'd2, 64'h5000);
        n = 0;
        while (!m0_write && n < 40) begin step(); n++; end
        check("t5_write_seen", 512'(m0_write), 512'(1'b1));
        check("t5_be", 512'(m0_byteenable), 512'({64{1'b1}}));
        step();
        step();
        reset = 1'b1;
        step();
        check("t5_reset", 512'({m0_write, busy, data_re}), 512'(3'b000));
        check("t5_reset_addr", 512'(m0_address), 512'd0);
        reset = 1'b0;
        m0_waitrequest = 1'b0;
        b_re = re_cnt; b_wr = wr_cnt;
        repeat (60) step();
        check("t5_abandoned", 512'({re_cnt - b_re, wr_cnt - b_wr}), 512'(0));

        // Full dmem with a base that wraps the 64-bit address space
        b_re = re_cnt; b_wr = wr_cnt;
        start(2'd3, 11'd1024, 64'hFFFF_FFFF_FFFF_FFC0);
        wait_done(25000, 0, n);
        step();
        check("t6_done_latency", 512'(n), 512'(19455));
        check("t6_wr_count", 512'(wr_cnt - b_wr), 512'(1024));
        check("t6_addr0", 512'(wr_addr_a[b_wr]), 512'(64'hFFFF_FFFF_FFFF_FFC0));
        check("t6_addr_wrap", 512'(wr_addr_a[b_wr + 1]), 512'(64'h0));
        check("t6_addr_last", 512'(wr_addr_a[b_wr + 1023]), 512'(64'hFF80));
        check("t6_re_count", 512'(re_cnt - b_re), 512'(16384));
        check("t6_last_daddr", 512'(re_addr_a[b_re + 16383]), 512'(18'h3FFFC));
        check("t6_last_word", 512'(wr_data_a[b_wr + 1023][31:0]), 512'(32'h40FF));

        // Oversized request is clamped to the dmem size
        b_re = re_cnt; b_wr = wr_cnt;
        start(2'd0, 11'h7FF, 64'h0);
        wait_done(25000, 0, n);
        step();
        check("t7_done_latency", 512'(n), 512'(19455));
        check("t7_wr_count", 512'(wr_cnt - b_wr), 512'(1024));
        check("t7_addr_last", 512'(wr_addr_a[b_wr + 1023]), 512'(64'hFFC0));
        check("t7_re_count", 512'(re_cnt - b_re), 512'(16384));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
